// File: rtl/regfile_wb_arbiter_if.sv
// Bundle of the writer handshakes, decode issue/scoreboard view and the
// register-file write port for regfile_wb_arbiter.
interface regfile_wb_arbiter_if #(
  parameter int unsigned XLEN = 32
);
  logic            a_valid;
  logic [4:0]      a_addr;
  logic [XLEN-1:0] a_data;
  logic            a_ready;

  logic            b_valid;
  logic [4:0]      b_addr;
  logic [XLEN-1:0] b_data;
  logic            b_ready;

  logic            issue_valid;
  logic [4:0]      issue_addr;
  logic [31:0]     busy;

  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic            starve_flag;

  // Requester side: writers, decode and the register file.
  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data, issue_valid, issue_addr,
    input  a_ready, b_ready, busy, rf_we, rf_waddr, rf_wdata, starve_flag
  );

  // Arbiter side.
  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data, issue_valid, issue_addr,
    output a_ready, b_ready, busy, rf_we, rf_waddr, rf_wdata, starve_flag
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: in-order writeback (A) has priority, the
// long-latency unit (B) is force-granted after MAX_WAIT refused cycles. A
// scoreboard tracks destinations of B operations still in flight.
module regfile_wb_arbiter #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_wb_arbiter_if.slave  bus
);

  typedef enum logic [0:0] {StAPri, StBForce} state_e;

  localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

  state_e          state_q;
  logic [3:0]      wait_cnt_q;
  logic [3:0]      wait_inc;
  logic            starve_q;
  logic            a_ready;
  logic            b_ready;
  logic            a_xfer;
  logic            b_xfer;
  logic            rf_we_q;
  logic [4:0]      rf_waddr_q;
  logic [XLEN-1:0] rf_wdata_q;
  logic [31:0]     busy_d;
  logic [31:0]     busy_q;

  // Grants depend only on state and valids, never on payload.
  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    unique case (state_q)
      StAPri: begin
        a_ready = bus.a_valid;
        b_ready = bus.b_valid && !bus.a_valid;
      end
      StBForce: begin
        b_ready = bus.b_valid;
      end
      default: ;
    endcase
  end

  assign a_xfer   = bus.a_valid && a_ready;
  assign b_xfer   = bus.b_valid && b_ready;
  assign wait_inc = (wait_cnt_q == 4'hf) ? 4'hf : wait_cnt_q + 4'd1;

  // Starvation FSM; starve_flag is registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StAPri;
      wait_cnt_q <= 4'd0;
      starve_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StAPri: begin
          if (bus.b_valid && !b_ready) begin
            wait_cnt_q <= wait_inc;
            if (wait_inc == MaxWait) begin
              state_q  <= StBForce;
              starve_q <= 1'b1;
            end
          end else begin
            wait_cnt_q <= 4'd0;
          end
        end
        StBForce: begin
          // Leave on the forced transfer, or if B withdraws its request.
          if (b_xfer || !bus.b_valid) begin
            state_q    <= StAPri;
            wait_cnt_q <= 4'd0;
            starve_q   <= 1'b0;
          end
        end
        default: begin
          state_q    <= StAPri;
          wait_cnt_q <= 4'd0;
          starve_q   <= 1'b0;
        end
      endcase
    end
  end

  // Register the winning write; x0 is accepted but never enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= 5'd0;
      rf_wdata_q <= '0;
    end else if (a_xfer) begin
      rf_we_q    <= (bus.a_addr != 5'd0);
      rf_waddr_q <= bus.a_addr;
      rf_wdata_q <= bus.a_data;
    end else if (b_xfer) begin
      rf_we_q    <= (bus.b_addr != 5'd0);
      rf_waddr_q <= bus.b_addr;
      rf_wdata_q <= bus.b_data;
    end else begin
      rf_we_q    <= 1'b0;
    end
  end

  // Scoreboard next state: clear on B return, then set on issue so set wins.
  always_comb begin
    busy_d = busy_q;
    if (b_xfer) begin
      busy_d[bus.b_addr] = 1'b0;
    end
    if (bus.issue_valid) begin
      busy_d[bus.issue_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 32'd0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign bus.a_ready     = a_ready;
  assign bus.b_ready     = b_ready;
  assign bus.busy        = busy_q;
  assign bus.rf_we       = rf_we_q;
  assign bus.rf_waddr    = rf_waddr_q;
  assign bus.rf_wdata    = rf_wdata_q;
  assign bus.starve_flag = starve_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios followed by
// randomized traffic, all compared against a behavioural model.
module tb_regfile_wb_arbiter;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned MAX_WAIT = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.XLEN(XLEN)) bus ();

  regfile_wb_arbiter #(
    .XLEN     (XLEN),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: how many consecutive cycles B has been refused, the pending
  // destination set, and the write expected on the port.
  int              m_refusals;
  bit [31:0]       m_busy;
  bit              m_we;
  bit [4:0]        m_waddr;
  bit [XLEN-1:0]   m_wdata;
  bit              last_a_xfer;
  bit              last_b_xfer;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_refusals = 0;
    m_busy     = '0;
    m_we       = 1'b0;
    m_waddr    = '0;
    m_wdata    = '0;
  endtask

  task automatic idle_inputs();
    bus.a_valid     = 1'b0;
    bus.a_addr      = '0;
    bus.a_data      = '0;
    bus.b_valid     = 1'b0;
    bus.b_addr      = '0;
    bus.b_data      = '0;
    bus.issue_valid = 1'b0;
    bus.issue_addr  = '0;
  endtask

  // One clock cycle: entered and left at posedge+1.
  task automatic cycle();
    bit forced, exp_ar, exp_br;
    @(negedge clk);
    forced = (m_refusals >= int'(MAX_WAIT));
    exp_ar = bus.a_valid && !forced;
    exp_br = bus.b_valid && (forced || !bus.a_valid);
    check_eq("a_ready", bus.a_ready, exp_ar);
    check_eq("b_ready", bus.b_ready, exp_br);
    check_eq("starve_flag", bus.starve_flag, forced);
    check_eq("rf_we", bus.rf_we, m_we);
    check_eq("rf_waddr", bus.rf_waddr, m_waddr);
    check_eq("rf_wdata", bus.rf_wdata, m_wdata);
    check_eq("busy", bus.busy, m_busy);
    if (bus.issue_valid && bus.issue_addr != 5'd0) begin
      assert (!m_busy[bus.issue_addr] || (exp_br && bus.b_addr == bus.issue_addr))
        else $error("issue to a register already pending: x%0d", bus.issue_addr);
    end
    last_a_xfer = exp_ar;
    last_b_xfer = exp_br;
    if (exp_ar) begin
      m_we = (bus.a_addr != 0); m_waddr = bus.a_addr; m_wdata = bus.a_data;
    end else if (exp_br) begin
      m_we = (bus.b_addr != 0); m_waddr = bus.b_addr; m_wdata = bus.b_data;
    end else begin
      m_we = 1'b0;
    end
    if (exp_br) m_busy[bus.b_addr] = 1'b0;
    if (bus.issue_valid && bus.issue_addr != 5'd0) m_busy[bus.issue_addr] = 1'b1;
    if (bus.b_valid && !exp_br) m_refusals = (m_refusals < 15) ? m_refusals + 1 : 15;
    else m_refusals = 0;
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse held for n clock edges; entered at posedge+1.
  task automatic do_reset(input int n);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("rst_rf_we", bus.rf_we, 0);
    check_eq("rst_rf_waddr", bus.rf_waddr, 0);
    check_eq("rst_rf_wdata", bus.rf_wdata, 0);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_starve", bus.starve_flag, 0);
    repeat (n) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    bit [4:0] ia;
    idle_inputs();
    model_reset();
    @(posedge clk);
    #1;

    // 1: reset with A requesting, then first write after release
    bus.a_valid = 1'b1; bus.a_addr = 5'd5; bus.a_data = 32'h1234;
    do_reset(3);
    #1;
    check_eq("t1_a_ready", bus.a_ready, 1);
    cycle();
    check_eq("t1_rf_we", bus.rf_we, 1);
    check_eq("t1_rf_waddr", bus.rf_waddr, 5);
    check_eq("t1_rf_wdata", bus.rf_wdata, 32'h1234);
    idle_inputs();
    cycle();

    // 2: contention, B forced after MAX_WAIT refusals
    bus.a_valid = 1'b1; bus.a_addr = 5'd2; bus.a_data = 32'h2222;
    bus.b_valid = 1'b1; bus.b_addr = 5'd7; bus.b_data = 32'hBEEF;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq("t2_b_refused", bus.b_ready, 0);
      cycle();
    end
    #1;
    check_eq("t2_starve", bus.starve_flag, 1);
    check_eq("t2_a_blocked", bus.a_ready, 0);
    check_eq("t2_b_forced", bus.b_ready, 1);
    cycle();
    bus.b_valid = 1'b0;
    #1;
    check_eq("t2_waddr", bus.rf_waddr, 7);
    check_eq("t2_wdata", bus.rf_wdata, 32'hBEEF);
    check_eq("t2_a_back", bus.a_ready, 1);
    idle_inputs();
    cycle();

    // 3: x0 writes from A and from B
    bus.a_valid = 1'b1; bus.a_addr = 5'd0; bus.a_data = 32'hFFFF_FFFF;
    #1;
    check_eq("t3_a_ready", bus.a_ready, 1);
    cycle();
    idle_inputs();
    check_eq("t3_a_we", bus.rf_we, 0);
    check_eq("t3_a_wdata", bus.rf_wdata, 32'hFFFF_FFFF);
    bus.b_valid = 1'b1; bus.b_addr = 5'd0; bus.b_data = 32'h0BAD_0BAD;
    #1;
    check_eq("t3_b_ready", bus.b_ready, 1);
    cycle();
    idle_inputs();
    check_eq("t3_b_we", bus.rf_we, 0);
    check_eq("t3_b_wdata", bus.rf_wdata, 32'h0BAD_0BAD);

    // 4: scoreboard set, clear, and same-cycle set+clear
    bus.issue_valid = 1'b1; bus.issue_addr = 5'd9;
    cycle();
    idle_inputs();
    check_eq("t4_set", bus.busy[9], 1);
    bus.b_valid = 1'b1; bus.b_addr = 5'd9; bus.b_data = 32'h99;
    cycle();
    idle_inputs();
    check_eq("t4_clear", bus.busy[9], 0);
    bus.b_valid = 1'b1; bus.b_addr = 5'd9; bus.b_data = 32'h999;
    bus.issue_valid = 1'b1; bus.issue_addr = 5'd9;
    cycle();
    idle_inputs();
    check_eq("t4_set_wins", bus.busy[9], 1);
    bus.b_valid = 1'b1; bus.b_addr = 5'd9; bus.b_data = 32'h9999;
    cycle();
    idle_inputs();
    cycle();

    // 5: B alone is granted immediately
    bus.b_valid = 1'b1; bus.b_addr = 5'd12; bus.b_data = 32'hC0DE;
    #1;
    check_eq("t5_b_ready", bus.b_ready, 1);
    cycle();
    idle_inputs();
    check_eq("t5_we", bus.rf_we, 1);
    check_eq("t5_waddr", bus.rf_waddr, 12);
    check_eq("t5_wdata", bus.rf_wdata, 32'hC0DE);
    check_eq("t5_starve", bus.starve_flag, 0);

    // 6: reset while in the forced state
    bus.issue_valid = 1'b1; bus.issue_addr = 5'd14;
    cycle();
    idle_inputs();
    bus.a_valid = 1'b1; bus.a_addr = 5'd3; bus.a_data = 32'h3333;
    bus.b_valid = 1'b1; bus.b_addr = 5'd14; bus.b_data = 32'hEEEE;
    repeat (4) cycle();
    check_eq("t6_forced", bus.starve_flag, 1);
    do_reset(2);
    #1;
    check_eq("t6_a_pri", bus.a_ready, 1);
    check_eq("t6_b_wait", bus.b_ready, 0);
    cycle();
    idle_inputs();
    cycle();

    // Randomized traffic honouring the hold-until-transfer rule
    for (int n = 0; n < 3000; n++) begin
      if (!bus.a_valid || last_a_xfer) begin
        bus.a_valid = ($urandom_range(0, 2) != 0);
        bus.a_addr  = 5'($urandom_range(0, 31));
        bus.a_data  = $urandom;
      end
      if (!bus.b_valid || last_b_xfer) begin
        bus.b_valid = ($urandom_range(0, 1) != 0);
        bus.b_addr  = 5'($urandom_range(0, 31));
        bus.b_data  = $urandom;
      end
      ia = 5'($urandom_range(0, 31));
      bus.issue_valid = ($urandom_range(0, 3) == 0) && !m_busy[ia] &&
                        !(bus.a_valid && bus.a_addr == ia);
      bus.issue_addr  = ia;
      if ($urandom_range(0, 799) == 0) begin
        do_reset(1);
        last_a_xfer = 1'b0;
        last_b_xfer = 1'b0;
      end else begin
        cycle();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port between two writers.
- Writer A is the in-order writeback path.
- Writer B is a long-latency unit (mul/div, late loads) that returns results out of band.
- A wins by default; a starvation counter forces a grant to B after a bounded wait.
- A destination scoreboard tracks B operations in flight so decode can stall on RAW and WAW hazards.

Parameters:
XLEN, 32, data width of register writes
MAX_WAIT, 4, cycles B may be refused while valid before it is force-granted (legal range 1..15)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
a_valid  input  1  writeback stage has a register write
a_addr  input  5  writeback destination register
a_data  input  XLEN  writeback data
a_ready  output  1  A write accepted this cycle
b_valid  input  1  long-latency unit has a result
b_addr  input  5  long-latency destination register
b_data  input  XLEN  long-latency result
b_ready  output  1  B write accepted this cycle
issue_valid  input  1  a B-unit operation is issued by decode
issue_addr  input  5  destination of the issued operation
busy  output  32  per-register pending-write mask from the scoreboard
rf_we  output  1  register-file write enable (registered)
rf_waddr  output  5  register-file write address (registered)
rf_wdata  output  XLEN  register-file write data (registered)
starve_flag  output  1  high while in ST_BFORCE

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values:
  - rf_we=0, rf_waddr=0, rf_wdata=0, busy=0.
  - State=ST_APRI, wait_cnt=0, starve_flag=0.
  - a_ready and b_ready follow from the reset state.
- Reset asserted mid-operation: the in-flight write is lost and the scoreboard clears.
- Handshake:
  - A transfer occurs when valid && ready on the same rising edge.
  - The requester holds valid and its payload stable until the transfer.
  - a_ready and b_ready are combinational from the state and the valids. They never depend on the payload.
  - At most one of a_ready/b_ready is high in any cycle.
- Grant logic:
  - ST_APRI: a_ready = a_valid; b_ready = b_valid && !a_valid.
  - ST_BFORCE: a_ready = 0; b_ready = b_valid.
- Write port:
  - The winner's addr/data are registered onto rf_waddr/rf_wdata. Latency is exactly 1 cycle from transfer to rf_we.
  - rf_we = transfer && addr != 0. A write to x0 is accepted (ready=1), but rf_we stays 0. rf_waddr and rf_wdata still update.
  - With no transfer, rf_we=0 and rf_waddr/rf_wdata hold their previous values.
- Starvation counter (wait_cnt, 4 bits):
  - ST_APRI, b_valid && !b_ready: wait_cnt += 1. When the incremented value equals MAX_WAIT, the next state is ST_BFORCE.
  - ST_APRI, B transfer or !b_valid: wait_cnt = 0.
  - ST_BFORCE, B transfer: go to ST_APRI with wait_cnt=0.
  - ST_BFORCE, b_valid falls without a transfer (protocol violation): go to ST_APRI with wait_cnt=0.
  - The counter saturates; it never wraps.
- Scoreboard:
  - Set: on issue_valid, busy[issue_addr] is set. An issue to x0 is ignored.
  - Clear: on a B transfer, busy[b_addr] is cleared.
  - Same-cycle set and clear of the same address: set wins, and the bit stays 1.
  - busy[0] is always 0.
  - busy is a registered output, visible the cycle after the event.
  - An issue to an already-busy register is illegal. The bench asserts on it; the RTL keeps the bit set.
  - A transfers never touch busy. Decode guarantees no A write targets a busy register.
- No combinational path from any input to rf_we, rf_waddr, rf_wdata or busy.

Test Plan:
1. Reset sequence: rst_n low for 3 cycles while a_valid=1 -> all registered outputs are 0 and busy=0. On release, a_ready=1 with a_addr=5, a_data=0x1234 -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234.
2. Contention with MAX_WAIT=4: a_valid=1 continuously and b_valid=1 (addr 7, data 0xBEEF) from cycle 0:
   - b_ready=0 on cycles 0-3.
   - Cycle 4: starve_flag=1, a_ready=0, b_ready=1.
   - Cycle 5: rf_waddr=7, rf_wdata=0xBEEF, and a_ready=1 again.
3. x0 writes: a_valid=1 with a_addr=0, data 0xFFFFFFFF -> a_ready=1, rf_we stays 0. Same for a B write to x0.
4. Scoreboard: issue addr 9 -> busy[9]=1 the next cycle. A later B transfer to 9 -> busy[9]=0 the cycle after. Issue 9 together with a B transfer to 9 in the same cycle -> busy[9] stays 1.
5. B alone: a_valid=0 and b_valid=1 -> immediate b_ready=1, wait_cnt stays 0, and the write appears 1 cycle later.
6. Reset mid-force: reach ST_BFORCE, then pulse rst_n low -> starve_flag=0, busy=0, and A priority is restored on release.
